atpg_entry_ctl: RTL and testbench

On-chip responder for the production test entry sequence that the tester drives onto the TST, SCL and SDA pads before scan patterns are applied. It sits in the chip-top test logic and decodes a keyed serial entry protocol. On a valid entry it asserts `atpg_en` and a registered test selection, which the pad muxes and scan-enable logic then use. It locks out after repeated bad keys and drops test mode as soon as TST is released.

---
 rtl/atpg_entry_ctl.sv | 188 ++++++++++++++++++
 tb/tb_atpg_entry_ctl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atpg_entry_ctl.sv
// Keyed production-test entry responder: sync pads, decode KEY+MODE, drive test mode.
// Latency: final MODE strobe to atpg_en/test_sel is one edge; TST release clears in 3 edges.
// Backpressure: none; tester paces SCL (>=3 cycles high/low), strobes outside KEY/MODE ignored.
module atpg_entry_ctl #(
  parameter logic [15:0] KEY      = 16'h1127,
  parameter int          TO_CYC   = 1023,
  parameter int          MAX_FAIL = 3
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       tst_pad,
  input  logic       scl_pad,
  input  logic       sda_pad,
  output logic       atpg_en,
  output logic       scan_mode,
  output logic [3:0] test_sel,
  output logic       lockout,
  output logic [2:0] st
);

  localparam int TW = $clog2(TO_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  localparam logic [TW-1:0] TMR_LAST = TW'(TO_CYC - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KEY    = 3'd1;
  localparam logic [2:0] ST_MODE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_LOCK   = 3'd4;

  // Pad synchronisers plus the delayed SCL copy used for edge detection
  logic [1:0] tst_sync_q;
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_dly_q;

  // Control state
  logic [2:0]    state_q, state_d;
  logic [14:0]   shr_q, shr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [FW-1:0] fail_q, fail_d;

  // Registered outputs
  logic       atpg_en_q, atpg_en_d;
  logic       scan_mode_q, scan_mode_d;
  logic [3:0] test_sel_q, test_sel_d;
  logic       lockout_q, lockout_d;

  logic        tst_s;
  logic        sda_s;
  logic        stb;
  logic        timeout;
  logic [15:0] shr_nx;
  logic [FW-1:0] fail_inc;

  assign tst_s    = tst_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign stb      = scl_sync_q[1] & ~scl_dly_q;
  assign timeout  = (tmr_q == TMR_LAST);
  // The 16th bit only matters in the cycle it arrives, so it is never stored
  assign shr_nx   = {shr_q, sda_s};
  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

  // State register: synchronisers, FSM state, datapath and output flops
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tst_sync_q  <= '0;
      scl_sync_q  <= '0;
      sda_sync_q  <= '0;
      scl_dly_q   <= 1'b0;
      state_q     <= ST_IDLE;
      shr_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      fail_q      <= '0;
      atpg_en_q   <= 1'b0;
      scan_mode_q <= 1'b0;
      test_sel_q  <= '0;
      lockout_q   <= 1'b0;
    end else begin
      tst_sync_q  <= {tst_sync_q[0], tst_pad};
      scl_sync_q  <= {scl_sync_q[0], scl_pad};
      sda_sync_q  <= {sda_sync_q[0], sda_pad};
      scl_dly_q   <= scl_sync_q[1];
      state_q     <= state_d;
      shr_q       <= shr_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      fail_q      <= fail_d;
      atpg_en_q   <= atpg_en_d;
      scan_mode_q <= scan_mode_d;
      test_sel_q  <= test_sel_d;
      lockout_q   <= lockout_d;
    end
  end

  // Next state: TST release beats timeout, timeout beats strobe, strobe beats hold
  always_comb begin
    state_d = state_q;
    shr_d   = shr_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    fail_d  = fail_q;
    if (!tst_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lockout_q) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_KEY;
            shr_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
          end
        end
        ST_KEY: begin
          if (timeout) begin
            state_d = ST_IDLE;
          end else if (stb) begin
            shr_d = shr_nx[14:0];
            tmr_d = '0;
            if (cnt_q == 5'd15) begin
              cnt_d = '0;
              if (shr_nx == KEY) begin
                state_d = ST_MODE;
              end else begin
                state_d = ST_LOCK;
                fail_d  = fail_inc;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_MODE: begin
          if (timeout) begin
            state_d = ST_IDLE;
          end else if (stb) begin
            shr_d = shr_nx[14:0];
            tmr_d = '0;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (shr_nx[7:4] == 4'hA) begin
                state_d = ST_ACTIVE;
                fail_d  = '0;
              end else begin
                state_d = ST_LOCK;
                fail_d  = fail_inc;
              end
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_ACTIVE: state_d = ST_ACTIVE;
        ST_LOCK:   state_d = ST_LOCK;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: computed from the next state so every output pin is a plain flop
  always_comb begin
    atpg_en_d  = (state_d == ST_ACTIVE);
    test_sel_d = 4'h0;
    if (state_d == ST_ACTIVE) begin
      test_sel_d = (state_q == ST_MODE) ? shr_nx[3:0] : test_sel_q;
    end
    scan_mode_d = atpg_en_d && (test_sel_d == 4'h0);
    lockout_d   = lockout_q | (fail_d == FAIL_MAX);
  end

  assign atpg_en   = atpg_en_q;
  assign scan_mode = scan_mode_q;
  assign test_sel  = test_sel_q;
  assign lockout   = lockout_q;
  assign st        = state_q;

endmodule

// File: tb/tb_atpg_entry_ctl.sv
// Bench for atpg_entry_ctl: vector table, hand-written corner sequences, random entries vs model.
// Latency: checks exact strobe-to-ACTIVE, TST release and timeout edge counts.
// Backpressure: n/a; pads driven on negedge, outputs sampled on negedge.
module tb_atpg_entry_ctl;

  logic       clk = 1'b0;
  logic       rstz = 1'b1;
  logic       tst_pad = 1'b0;
  logic       scl_pad = 1'b0;
  logic       sda_pad = 1'b0;
  logic       atpg_en;
  logic       scan_mode;
  logic [3:0] test_sel;
  logic       lockout;
  logic [2:0] st;

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] GOOD_KEY = 16'h1127;

  atpg_entry_ctl dut (
    .clk       (clk),
    .rstz      (rstz),
    .tst_pad   (tst_pad),
    .scl_pad   (scl_pad),
    .sda_pad   (sda_pad),
    .atpg_en   (atpg_en),
    .scan_mode (scan_mode),
    .test_sel  (test_sel),
    .lockout   (lockout),
    .st        (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] key;
    logic [7:0]  mode;
    logic [2:0]  e_st;
    logic        e_en;
    logic        e_scan;
    logic [3:0]  e_sel;
    logic        e_lock;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_st, input logic e_en,
                            input logic e_scan, input logic [3:0] e_sel, input logic e_lock);
    chk($sformatf("%s.st", tag), 16'(st), 16'(e_st));
    chk($sformatf("%s.atpg_en", tag), 16'(atpg_en), 16'(e_en));
    chk($sformatf("%s.scan_mode", tag), 16'(scan_mode), 16'(e_scan));
    chk($sformatf("%s.test_sel", tag), 16'(test_sel), 16'(e_sel));
    chk($sformatf("%s.lockout", tag), 16'(lockout), 16'(e_lock));
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_pad = b;
    wait_n(3);
    scl_pad = 1'b1;
    wait_n(3);
    scl_pad = 1'b0;
    wait_n(3);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic entry(input logic [15:0] key, input logic [7:0] mode);
    tst_pad = 1'b1;
    send_bits(key, 16);
    send_bits({8'h00, mode}, 8);
  endtask

  task automatic release_tst();
    tst_pad = 1'b0;
    wait_n(4);
  endtask

  task automatic do_reset();
    tst_pad = 1'b0;
    scl_pad = 1'b0;
    sda_pad = 1'b0;
    @(negedge clk);
    rstz = 1'b0;
    wait_n(2);
    rstz = 1'b1;
    wait_n(2);
  endtask

  // Transaction-level reference model state
  int          m_fail;
  logic        m_lock;
  logic [15:0] r_key;
  logic [7:0]  r_mode;
  logic [2:0]  x_st;
  logic [3:0]  x_sel;

  initial begin
    vt[0] = '{16'h1127, 8'hA0, 3'd3, 1'b1, 1'b1, 4'h0, 1'b0};
    vt[1] = '{16'h1127, 8'hA5, 3'd3, 1'b1, 1'b0, 4'h5, 1'b0};
    vt[2] = '{16'h1126, 8'hA0, 3'd4, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[3] = '{16'h1127, 8'h50, 3'd4, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[4] = '{16'h1127, 8'hAF, 3'd3, 1'b1, 1'b0, 4'hF, 1'b0};
    vt[5] = '{16'h1126, 8'hA0, 3'd4, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[6] = '{16'h1127, 8'h5A, 3'd4, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[7] = '{16'h0000, 8'hA0, 3'd4, 1'b0, 1'b0, 4'h0, 1'b1};
    vt[8] = '{16'h1127, 8'hA0, 3'd4, 1'b0, 1'b0, 4'h0, 1'b1};

    // Reset state
    #1 rstz = 1'b0;
    wait_n(2);
    check_outs("reset", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    rstz = 1'b1;
    wait_n(2);

    // Good entry with exact edge timing
    tst_pad = 1'b1;
    wait_n(2);
    chk("tst_sync_idle", 16'(st), 16'd0);
    wait_n(1);
    chk("tst_sync_key", 16'(st), 16'd1);
    send_bits(GOOD_KEY, 16);
    chk("key_to_mode", 16'(st), 16'd2);
    send_bits(16'h0050, 7);
    sda_pad = 1'b0;
    wait_n(3);
    scl_pad = 1'b1;
    wait_n(2);
    chk("last_stb_pending", 16'(st), 16'd2);
    chk("last_stb_pending_en", 16'(atpg_en), 16'd0);
    wait_n(1);
    check_outs("good_entry", 3'd3, 1'b1, 1'b1, 4'h0, 1'b0);
    scl_pad = 1'b0;
    wait_n(3);
    tst_pad = 1'b0;
    wait_n(2);
    chk("release_hold_en", 16'(atpg_en), 16'd1);
    wait_n(1);
    check_outs("release", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_n(1);

    // Vector table: selections, bad keys, bad nibble, recovery, lockout
    for (int i = 0; i < 9; i++) begin
      entry(vt[i].key, vt[i].mode);
      check_outs($sformatf("vec%0d", i), vt[i].e_st, vt[i].e_en, vt[i].e_scan, vt[i].e_sel, vt[i].e_lock);
      if (vt[i].mode == 8'hA5 && vt[i].e_st == 3'd3) begin
        send_bits(16'h0007, 3);
        chk("active_ignores_stb_sel", 16'(test_sel), 16'h5);
        chk("active_ignores_stb_st", 16'(st), 16'd3);
      end
      release_tst();
      chk($sformatf("vec%0d_idle", i), 16'(st), 16'd0);
    end

    // Locked device goes to LOCK; asynchronous reset clears lockout without a clock
    tst_pad = 1'b1;
    wait_n(4);
    chk("locked_entry", 16'(st), 16'd4);
    @(negedge clk);
    #2 rstz = 1'b0;
    #1 check_outs("async_clear_lock", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    tst_pad = 1'b0;
    rstz = 1'b1;
    wait_n(4);

    // Timeout after 10 key bits: no fail counted (two prior fails would otherwise lock)
    do_reset();
    entry(16'h1126, 8'hA0);
    release_tst();
    entry(16'h1126, 8'hA0);
    release_tst();
    chk("two_fails_no_lock", 16'(lockout), 16'd0);
    tst_pad = 1'b1;
    send_bits(GOOD_KEY >> 7, 9);
    sda_pad = GOOD_KEY[6];
    wait_n(3);
    scl_pad = 1'b1;
    wait_n(3);
    scl_pad = 1'b0;
    wait_n(1022);
    chk("timeout_before", 16'(st), 16'd1);
    wait_n(1);
    chk("timeout_idle", 16'(st), 16'd0);
    wait_n(1);
    chk("timeout_rekey", 16'(st), 16'd1);
    send_bits(GOOD_KEY, 16);
    send_bits(16'h00A3, 8);
    check_outs("after_timeout", 3'd3, 1'b1, 1'b0, 4'h3, 1'b0);
    release_tst();

    // Abort mid-MODE: no fail counted
    do_reset();
    entry(16'h1126, 8'hA0);
    release_tst();
    entry(16'hFFFF, 8'hA0);
    release_tst();
    tst_pad = 1'b1;
    send_bits(GOOD_KEY, 16);
    send_bits(16'h000A, 4);
    chk("abort_in_mode", 16'(st), 16'd2);
    tst_pad = 1'b0;
    wait_n(3);
    chk("abort_idle", 16'(st), 16'd0);
    wait_n(1);
    entry(GOOD_KEY, 8'hA7);
    check_outs("after_abort", 3'd3, 1'b1, 1'b0, 4'h7, 1'b0);
    release_tst();

    // Asynchronous reset mid-KEY
    tst_pad = 1'b1;
    send_bits(GOOD_KEY >> 11, 5);
    chk("mid_key", 16'(st), 16'd1);
    @(negedge clk);
    #2 rstz = 1'b0;
    #1 check_outs("async_mid_key", 3'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    tst_pad = 1'b0;
    rstz = 1'b1;
    wait_n(4);

    // Random entries against the transaction-level model
    do_reset();
    m_fail = 0;
    m_lock = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (m_lock && $urandom_range(0, 1) == 1) begin
        do_reset();
        m_fail = 0;
        m_lock = 1'b0;
      end
      r_key  = ($urandom_range(0, 1) == 1) ? GOOD_KEY : 16'($urandom);
      r_mode = ($urandom_range(0, 1) == 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
      x_sel = 4'h0;
      if (m_lock) begin
        x_st = 3'd4;
      end else if (r_key != GOOD_KEY || r_mode[7:4] != 4'hA) begin
        x_st = 3'd4;
        m_fail = (m_fail + 1 > 3) ? 3 : m_fail + 1;
      end else begin
        x_st = 3'd3;
        x_sel = r_mode[3:0];
        m_fail = 0;
      end
      if (m_fail == 3) m_lock = 1'b1;
      entry(r_key, r_mode);
      check_outs($sformatf("rnd%0d k=%h m=%h", n, r_key, r_mode), x_st, x_st == 3'd3,
                 (x_st == 3'd3) && (x_sel == 4'h0), x_sel, m_lock);
      release_tst();
      chk($sformatf("rnd%0d_idle", n), 16'(st), 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
